// File: rtl/qwac_pkg.sv
// Shared types and default widths for the matrix-vector MAC engines.
package qwac_pkg;

  localparam int IN_BITS_DEF  = 8;
  localparam int OUT_BITS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mvm_state_t;

  typedef logic signed [IN_BITS_DEF-1:0]  in_elem_t;
  typedef logic signed [OUT_BITS_DEF-1:0] out_elem_t;

endpackage

// File: rtl/mat_vec_mac_engine_mac_unit.sv
// Combinational multiply-accumulate: sum = acc + a*b, all modulo 2^OUT_BITS.
module mac_unit #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 32
) (
  input  logic signed [IN_BITS-1:0]  a,
  input  logic signed [OUT_BITS-1:0] b,
  input  logic        [OUT_BITS-1:0] acc,
  output logic        [OUT_BITS-1:0] sum
);

  logic [OUT_BITS-1:0] prod;

  // Only the low OUT_BITS of the product survive, so multiplying at OUT_BITS
  // width with a sign-extended gives the same truncated result as full width.
  assign prod = OUT_BITS'($signed(a) * $signed(b));
  assign sum  = acc + prod;

endmodule

// File: rtl/mat_vec_mac_engine.sv
// Sequential matrix-vector multiply: one MAC per clock over TE vectors,
// results held under valid/ready until the consumer takes them.
import qwac_pkg::*;

module mat_vec_mac_engine #(
  parameter int VEC_LEN  = 4,
  parameter int MAT_R    = 8,
  parameter int TE       = 1,
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            start,
  output logic                                            in_ready,
  input  logic signed [TE-1:0][VEC_LEN-1:0][IN_BITS-1:0]  in_vector,
  input  logic signed [MAT_R-1:0][VEC_LEN-1:0][OUT_BITS-1:0] mat,
  output logic signed [TE-1:0][MAT_R-1:0][OUT_BITS-1:0]   out_vecs,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic                                            busy
);

  localparam int TW = (TE > 1)      ? $clog2(TE)      : 1;
  localparam int RW = (MAT_R > 1)   ? $clog2(MAT_R)   : 1;
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(TE - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAT_R - 1);
  localparam logic [CW-1:0] C_LAST = CW'(VEC_LEN - 1);

  mvm_state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [OUT_BITS-1:0] acc_q, acc_d;
  logic [TE-1:0][VEC_LEN-1:0][IN_BITS-1:0]     vec_q, vec_d;
  logic [MAT_R-1:0][VEC_LEN-1:0][OUT_BITS-1:0] mat_q, mat_d;
  logic [TE-1:0][MAT_R-1:0][OUT_BITS-1:0]      out_q, out_d;
  logic [OUT_BITS-1:0] mac_sum;

  mac_unit #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_mac (
    .a   (vec_q[t_q][c_q]),
    .b   (mat_q[r_q][c_q]),
    .acc (acc_q),
    .sum (mac_sum)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    r_d     = r_q;
    c_d     = c_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    mat_d   = mat_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = in_vector;
          mat_d   = mat;
          acc_d   = '0;
          t_d     = '0;
          r_d     = '0;
          c_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (c_q != C_LAST) begin
          acc_d = mac_sum;
          c_d   = c_q + 1'b1;
        end else begin
          out_d[t_q][r_q] = mac_sum;
          acc_d = '0;
          c_d   = '0;
          if (r_q != R_LAST) begin
            r_d = r_q + 1'b1;
          end else begin
            r_d = '0;
            // t is left at its last value on completion; the next accept clears it.
            if (t_q != T_LAST) t_d = t_q + 1'b1;
            else               state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      vec_q   <= '0;
      mat_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      mat_q   <= mat_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_vecs  = out_q;

endmodule
